// File: rtl/fir_mac_engine_if.sv
// fir_mac_engine_if: handshake bundle between the FIR MAC engine and its
// neighbours.
//   coef_*    : coefficient write port (coef_ready high when a write lands)
//   hist_clr  : zero the sample history
//   in_*      : upstream sample stream (valid/ready)
//   out_*     : downstream result stream (valid/ready) plus saturation flag
//   busy      : engine is not idle
// master = the environment driving the engine, slave = the engine itself.
interface fir_mac_engine_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 16,
  parameter int AW     = 6
);
  logic                     coef_we;
  logic [AW-1:0]            coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     coef_ready;
  logic                     hist_clr;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_ready;
  logic                     out_valid;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_sat;
  logic                     out_ready;
  logic                     busy;

  modport master (
    output coef_we, coef_addr, coef_data, hist_clr, in_valid, in_data, out_ready,
    input  coef_ready, in_ready, out_valid, out_data, out_sat, busy
  );

  modport slave (
    input  coef_we, coef_addr, coef_data, hist_clr, in_valid, in_data, out_ready,
    output coef_ready, in_ready, out_valid, out_data, out_sat, busy
  );
endinterface

// File: rtl/fir_mac_engine.sv
// fir_mac_engine: TAPS-tap FIR filter with one time-shared multiply-accumulate.
// Each accepted sample is written into a circular history, then TAPS MAC
// cycles accumulate coef[k] * hist[newest-k], the sum is rounded (half-up),
// shifted right by SHIFT and saturated to OUT_W bits.
// Ports:
//   clk  : single clock
//   rst  : synchronous active-high reset
//   bus  : fir_mac_engine_if.slave (coefficient port, hist_clr, in/out
//          valid/ready streams, out_sat, busy)
// Sample period is TAPS+3 cycles minimum; out_valid rises TAPS+1 edges
// after the accept edge.
module fir_mac_engine #(
  parameter int TAPS   = 64,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 15,
  parameter int AW     = $clog2(TAPS)
) (
  input logic             clk,
  input logic             rst,
  fir_mac_engine_if.slave bus
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + AW;
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [AW-1:0] LAST_IDX = AW'(TAPS - 1);
  // Rounding constant is half an output LSB, or nothing when no shift.
  localparam logic signed [ACC_W:0] RND = (ACC_W+1)'(SHIFT > 0) << RND_SH;
  localparam logic signed [ACC_W:0] MAX_V =
    {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MIN_V =
    {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_SAT  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  state_t state_r, state_nxt_s;

  logic signed [COEF_W-1:0] coef_r [TAPS];
  logic signed [DATA_W-1:0] hist_r [TAPS];
  logic [AW-1:0]            wr_ptr_r;
  logic [AW-1:0]            rd_ptr_r;
  logic [AW-1:0]            k_r;
  logic signed [ACC_W-1:0]  acc_r;
  logic                     out_valid_r;
  logic signed [OUT_W-1:0]  out_data_r;
  logic                     out_sat_r;

  logic                     in_ready_s;
  logic                     coef_ready_s;
  logic                     busy_s;
  logic                     accept_s;
  logic                     clr_s;
  logic                     cw_s;
  logic signed [PROD_W-1:0] coef_ext_s;
  logic signed [PROD_W-1:0] hist_ext_s;
  logic signed [PROD_W-1:0] prod_s;
  logic signed [ACC_W-1:0]  prod_acc_s;
  logic signed [ACC_W:0]    acc_ext_s;
  logic signed [ACC_W:0]    rnd_sum_s;
  logic signed [ACC_W:0]    shifted_s;
  logic signed [OUT_W-1:0]  sat_data_s;
  logic                     sat_flag_s;

  // Circular increment that also works for non-power-of-two TAPS.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == LAST_IDX) begin
      return '0;
    end else begin
      return p + AW'(1);
    end
  endfunction

  // Circular decrement that also works for non-power-of-two TAPS.
  function automatic logic [AW-1:0] ptr_dec(input logic [AW-1:0] p);
    if (p == '0) begin
      return LAST_IDX;
    end else begin
      return p - AW'(1);
    end
  endfunction

  assign accept_s = in_ready_s & bus.in_valid;
  assign clr_s    = (state_r == ST_IDLE) & bus.hist_clr;
  assign cw_s     = coef_ready_s & bus.coef_we;

  // Full-precision signed product: operands are sign-extended before multiply.
  assign coef_ext_s = PROD_W'(coef_r[k_r]);
  assign hist_ext_s = PROD_W'(hist_r[rd_ptr_r]);
  assign prod_s     = coef_ext_s * hist_ext_s;
  assign prod_acc_s = ACC_W'(prod_s);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_MAC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MAC: begin
        if (k_r == LAST_IDX) begin
          state_nxt_s = ST_SAT;
        end else begin
          state_nxt_s = ST_MAC;
        end
      end
      ST_SAT: begin
        state_nxt_s = ST_OUT;
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State-decoded handshake outputs; hist_clr blocks a sample accept.
  always_comb begin
    in_ready_s   = 1'b0;
    coef_ready_s = 1'b0;
    busy_s       = 1'b1;
    case (state_r)
      ST_IDLE: begin
        coef_ready_s = 1'b1;
        busy_s       = 1'b0;
        if (bus.hist_clr) begin
          in_ready_s = 1'b0;
        end else begin
          in_ready_s = 1'b1;
        end
      end
      default: begin
        in_ready_s   = 1'b0;
        coef_ready_s = 1'b0;
        busy_s       = 1'b1;
      end
    endcase
  end

  // Coefficient store; writes land only while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        coef_r[i] <= '0;
      end
    end else if (cw_s && (bus.coef_addr <= LAST_IDX)) begin
      coef_r[bus.coef_addr] <= bus.coef_data;
    end
  end

  // Circular sample history and write pointer.
  always_ff @(posedge clk) begin
    if (rst || clr_s) begin
      for (int i = 0; i < TAPS; i++) begin
        hist_r[i] <= '0;
      end
      wr_ptr_r <= '0;
    end else if (accept_s) begin
      hist_r[wr_ptr_r] <= bus.in_data;
      wr_ptr_r         <= ptr_inc(wr_ptr_r);
    end
  end

  // MAC datapath: the read pointer walks backwards from the newest sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r    <= '0;
      k_r      <= '0;
      rd_ptr_r <= '0;
    end else if (accept_s) begin
      acc_r    <= '0;
      k_r      <= '0;
      rd_ptr_r <= wr_ptr_r;
    end else if (state_r == ST_MAC) begin
      acc_r    <= acc_r + prod_acc_s;
      k_r      <= k_r + AW'(1);
      rd_ptr_r <= ptr_dec(rd_ptr_r);
    end
  end

  // Round half-up, arithmetic shift, then clip to the signed output range.
  always_comb begin
    acc_ext_s = {acc_r[ACC_W-1], acc_r};
    rnd_sum_s = acc_ext_s + RND;
    shifted_s = rnd_sum_s >>> SHIFT;
    if (shifted_s > MAX_V) begin
      sat_data_s = MAX_V[OUT_W-1:0];
      sat_flag_s = 1'b1;
    end else if (shifted_s < MIN_V) begin
      sat_data_s = MIN_V[OUT_W-1:0];
      sat_flag_s = 1'b1;
    end else begin
      sat_data_s = shifted_s[OUT_W-1:0];
      sat_flag_s = 1'b0;
    end
  end

  // Result registers: loaded in SAT, held until the consumer takes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_sat_r   <= 1'b0;
    end else if (state_r == ST_SAT) begin
      out_valid_r <= 1'b1;
      out_data_r  <= sat_data_s;
      out_sat_r   <= sat_flag_s;
    end else if ((state_r == ST_OUT) && bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.coef_ready = coef_ready_s;
  assign bus.busy       = busy_s;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_data   = out_data_r;
  assign bus.out_sat    = out_sat_r;

endmodule

// File: tb/tb_fir_mac_engine.sv
// tb_fir_mac_engine: drives two engines (SHIFT=0 and SHIFT=2, TAPS=4) in
// lockstep from the same stimulus and compares both against hand-computed
// tables, directed corner sequences and an arithmetic reference model.
module tb_fir_mac_engine;

  logic clk = 1'b0;
  logic rst;
  logic coef_we;
  logic [1:0] coef_addr;
  logic signed [15:0] coef_data;
  logic hist_clr;
  logic in_valid;
  logic signed [15:0] in_data;
  logic out_ready;

  int n_vec = 0;
  int n_err = 0;

  longint m_coef [4];
  longint m_hist [4];

  always #5 clk = ~clk;

  fir_mac_engine_if #(.DATA_W(16), .COEF_W(16), .OUT_W(16), .AW(2)) if0 ();
  fir_mac_engine_if #(.DATA_W(16), .COEF_W(16), .OUT_W(16), .AW(2)) if2 ();

  assign if0.coef_we   = coef_we;
  assign if0.coef_addr = coef_addr;
  assign if0.coef_data = coef_data;
  assign if0.hist_clr  = hist_clr;
  assign if0.in_valid  = in_valid;
  assign if0.in_data   = in_data;
  assign if0.out_ready = out_ready;
  assign if2.coef_we   = coef_we;
  assign if2.coef_addr = coef_addr;
  assign if2.coef_data = coef_data;
  assign if2.hist_clr  = hist_clr;
  assign if2.in_valid  = in_valid;
  assign if2.in_data   = in_data;
  assign if2.out_ready = out_ready;

  fir_mac_engine #(.TAPS(4), .DATA_W(16), .COEF_W(16), .OUT_W(16), .SHIFT(0), .AW(2))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  fir_mac_engine #(.TAPS(4), .DATA_W(16), .COEF_W(16), .OUT_W(16), .SHIFT(2), .AW(2))
    dut2 (.clk(clk), .rst(rst), .bus(if2));

  typedef struct {
    bit load;
    int c0, c1, c2, c3;
    int smp;
    int e0, s0, e2, s2;
  } vec_t;

  vec_t tbl [18];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      m_coef[i] = 0;
      m_hist[i] = 0;
    end
  endtask

  task automatic m_push(input longint s);
    for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = s;
  endtask

  // y = clip(floor((sum coef[k]*x[n-k] + half) / 2^sh))
  task automatic m_expect(input int sh, output longint v, output longint sat);
    longint acc = 0;
    for (int k = 0; k < 4; k++) acc += m_coef[k] * m_hist[k];
    if (sh > 0) acc += longint'(1) << (sh - 1);
    acc = acc >>> sh;
    if (acc > 32767) begin
      v = 32767; sat = 1;
    end else if (acc < -32768) begin
      v = -32768; sat = 1;
    end else begin
      v = acc; sat = 0;
    end
  endtask

  task automatic write_coef(input int a, input int d);
    coef_we = 1'b1; coef_addr = 2'(a); coef_data = 16'(d);
    tick();
    coef_we = 1'b0;
    m_coef[a] = d;
  endtask

  task automatic accept(input int s, input bit cw, input int ca, input int cd);
    int w = 0;
    while (!if0.in_ready && w < 30) begin
      tick();
      w++;
    end
    chk("in_ready_wait", if0.in_ready, 1);
    in_valid = 1'b1; in_data = 16'(s);
    if (cw) begin
      coef_we = 1'b1; coef_addr = 2'(ca); coef_data = 16'(cd);
    end
    tick();
    in_valid = 1'b0; coef_we = 1'b0;
    if (cw) m_coef[ca] = cd;
    m_push(s);
  endtask

  task automatic wait_out(input int start, output int lat);
    lat = start;
    while (!if0.out_valid && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  // Check both results, then let the transfer edge pass (out_ready must be 1).
  task automatic take(input string nm, input longint e0, input longint s0,
                      input longint e2, input longint s2);
    chk({nm, "_valid"}, {if0.out_valid, if2.out_valid}, 3);
    chk({nm, "_d0"}, $signed(if0.out_data), e0);
    chk({nm, "_s0"}, if0.out_sat, s0);
    chk({nm, "_d2"}, $signed(if2.out_data), e2);
    chk({nm, "_s2"}, if2.out_sat, s2);
    tick();
    chk({nm, "_taken"}, {if0.out_valid, if2.out_valid}, 0);
  endtask

  function automatic int rnd16();
    logic [15:0] t;
    if ($urandom_range(0, 3) == 0) begin
      t = 16'($urandom);
      return int'($signed(t));
    end else begin
      return int'($urandom_range(0, 400)) - 200;
    end
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int imp_e0 [4];
    int imp_e2 [4];
    longint v0, v2, q0, q2;

    tbl[0]  = '{1'b1, 1000, 2000, 3000, 4000, 1, 1000, 0, 250, 0};
    tbl[1]  = '{1'b0, 0, 0, 0, 0, 0, 2000, 0, 500, 0};
    tbl[2]  = '{1'b0, 0, 0, 0, 0, 0, 3000, 0, 750, 0};
    tbl[3]  = '{1'b0, 0, 0, 0, 0, 0, 4000, 0, 1000, 0};
    tbl[4]  = '{1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{1'b1, 32767, 32767, 32767, 32767, 32767, 32767, 1, 32767, 1};
    tbl[6]  = '{1'b0, 0, 0, 0, 0, 32767, 32767, 1, 32767, 1};
    tbl[7]  = '{1'b0, 0, 0, 0, 0, 32767, 32767, 1, 32767, 1};
    tbl[8]  = '{1'b0, 0, 0, 0, 0, 32767, 32767, 1, 32767, 1};
    tbl[9]  = '{1'b0, 0, 0, 0, 0, -32768, 32767, 1, 32767, 1};
    tbl[10] = '{1'b0, 0, 0, 0, 0, -32768, -32768, 1, -16383, 0};
    tbl[11] = '{1'b0, 0, 0, 0, 0, -32768, -32768, 1, -32768, 1};
    tbl[12] = '{1'b0, 0, 0, 0, 0, -32768, -32768, 1, -32768, 1};
    tbl[13] = '{1'b1, 6, 0, 0, 0, 1, 6, 0, 2, 0};
    tbl[14] = '{1'b0, 0, 0, 0, 0, -1, -6, 0, -1, 0};
    tbl[15] = '{1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[16] = '{1'b0, 0, 0, 0, 0, 3, 18, 0, 5, 0};
    tbl[17] = '{1'b0, 0, 0, 0, 0, -3, -18, 0, -4, 0};
    imp_e0 = '{1, 10, 100, 1000};
    imp_e2 = '{0, 3, 25, 250};

    rst = 1'b1; coef_we = 1'b0; coef_addr = 2'd0; coef_data = 16'sd0;
    hist_clr = 1'b0; in_valid = 1'b0; in_data = 16'sd0; out_ready = 1'b1;
    m_reset();
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", {if0.out_valid, if2.out_valid}, 0);
    chk("rst_out_data", if0.out_data, 0);
    chk("rst_out_sat", if0.out_sat, 0);
    chk("rst_busy", if0.busy, 0);
    chk("rst_in_ready", if0.in_ready, 1);
    chk("rst_coef_ready", if0.coef_ready, 1);

    // Table: impulse, saturation, rounding
    for (int i = 0; i < 18; i++) begin
      if (tbl[i].load) begin
        write_coef(0, tbl[i].c0);
        write_coef(1, tbl[i].c1);
        write_coef(2, tbl[i].c2);
        write_coef(3, tbl[i].c3);
      end
      accept(tbl[i].smp, 1'b0, 0, 0);
      wait_out(0, lat);
      chk("tbl_latency", lat, 5);
      take($sformatf("tbl%0d", i), tbl[i].e0, tbl[i].s0, tbl[i].e2, tbl[i].s2);
    end

    // Backpressure: result held, pending sample waits, accepted after transfer
    out_ready = 1'b0;
    accept(100, 1'b0, 0, 0);
    wait_out(0, lat);
    chk("bp_latency", lat, 5);
    chk("bp_d2", $signed(if2.out_data), 150);
    in_valid = 1'b1; in_data = 16'sd7;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", if0.out_valid, 1);
      chk("bp_data", $signed(if0.out_data), 600);
      chk("bp_in_ready", if0.in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_xfer_valid", if0.out_valid, 0);
    chk("bp_idle_in_ready", if0.in_ready, 1);
    tick();
    in_valid = 1'b0;
    m_push(7);
    chk("bp_accepted_busy", if0.busy, 1);
    wait_out(0, lat);
    chk("bp_latency2", lat, 5);
    take("bp_pending", 42, 0, 11, 0);

    // Coefficient lock during MAC
    accept(4, 1'b0, 0, 0);
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 16'sd5;
    #1;
    chk("lock_coef_ready", if0.coef_ready, 0);
    tick();
    coef_we = 1'b0;
    wait_out(1, lat);
    chk("lock_latency", lat, 5);
    take("lock_old", 24, 0, 6, 0);
    write_coef(0, 5);
    accept(4, 1'b0, 0, 0);
    wait_out(0, lat);
    take("lock_new", 20, 0, 5, 0);

    // Reset mid-MAC aborts; coefficients and history come back zero
    accept(11, 1'b0, 0, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_reset();
    for (int i = 0; i < 8; i++) begin
      chk("rst_mid_no_valid", {if0.out_valid, if2.out_valid}, 0);
      tick();
    end
    chk("rst_mid_busy", if0.busy, 0);
    accept(9, 1'b0, 0, 0);
    wait_out(0, lat);
    chk("rst_latency", lat, 5);
    take("rst_zero_coef", 0, 0, 0, 0);

    // hist_clr wins over in_valid, then impulse from a clean history
    write_coef(0, 1); write_coef(1, 10); write_coef(2, 100); write_coef(3, 1000);
    hist_clr = 1'b1; in_valid = 1'b1; in_data = 16'sd55;
    #1;
    chk("clr_in_ready", if0.in_ready, 0);
    tick();
    hist_clr = 1'b0; in_valid = 1'b0;
    chk("clr_no_accept", if0.busy, 0);
    for (int i = 0; i < 4; i++) m_hist[i] = 0;
    for (int i = 0; i < 4; i++) begin
      accept((i == 0) ? 1 : 0, 1'b0, 0, 0);
      wait_out(0, lat);
      chk("clr_latency", lat, 5);
      take($sformatf("clr_imp%0d", i), imp_e0[i], 0, imp_e2[i], 0);
    end

    // Randomized traffic against the reference model
    for (int it = 0; it < 40; it++) begin
      int d;
      bit cw;
      int ca, cd;
      if ($urandom_range(0, 2) == 0) write_coef(int'($urandom_range(0, 3)), rnd16());
      cw = ($urandom_range(0, 3) == 0);
      ca = int'($urandom_range(0, 3));
      cd = rnd16();
      d = int'($urandom_range(0, 3));
      out_ready = (d == 0);
      accept(rnd16(), cw, ca, cd);
      m_expect(0, v0, q0);
      m_expect(2, v2, q2);
      wait_out(0, lat);
      chk("rnd_latency", lat, 5);
      repeat (d) tick();
      out_ready = 1'b1;
      take("rnd", v0, q0, v2, q2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fir_mac_engine.md
Name: fir_mac_engine

Overview:
- Parametrised single-clock successor to the current 64-tap/16-bit FIR core.
- Stores TAPS signed coefficients and a TAPS-deep circular sample history. Computes one output per accepted sample with a single time-shared multiply-accumulate.
- Applies rounding, right shift and saturation to the result.
- Connects to the upstream FIFO and downstream consumer through valid/ready handshakes. A coefficient port, locked while a computation runs, replaces the free-running cload path.

Parameters:
- TAPS, 64, number of filter taps (≥2).
- DATA_W, 16, signed input sample width.
- COEF_W, 16, signed coefficient width.
- OUT_W, 16, signed output width.
- SHIFT, 15, arithmetic right shift applied to the accumulator before saturation (0 = none).
- AW, $clog2(TAPS), coefficient/sample address width; ACC_W = DATA_W+COEF_W+AW internal.

Ports:
- clk, input, 1, single clock.
- rst, input, 1, synchronous active-high reset.
- coef_we, input, 1, coefficient write strobe.
- coef_addr, input, AW, coefficient index (0 = applied to newest sample).
- coef_data, input, COEF_W, signed coefficient.
- coef_ready, output, 1, high when a coefficient write will be performed.
- hist_clr, input, 1, zero the sample history (IDLE only).
- in_valid, input, 1, sample valid.
- in_data, input, DATA_W, signed sample.
- in_ready, output, 1, sample accepted when in_valid&in_ready.
- out_valid, output, 1, result valid, held until taken.
- out_data, output, OUT_W, signed saturated result.
- out_sat, output, 1, result was clipped; qualified by out_valid.
- busy, output, 1, state != IDLE.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. All state is sampled on the rising edge of clk.
- Reset values: state=IDLE, out_valid=0, out_data=0, out_sat=0, busy=0. All coefficients and history entries are 0, the write pointer is 0 and the accumulator is 0. rst mid-operation aborts immediately; no partial result is emitted.
- States: IDLE, MAC, SAT, OUT.
- IDLE:
  - in_ready=1 and coef_ready=1.
  - If in_valid: write in_data at wr_ptr, advance wr_ptr (mod TAPS), clear acc, set k=0, go to MAC.
- MAC:
  - Each cycle: acc += coef[k] * hist[(newest - k) mod TAPS], with full-precision signed products. Then k++.
  - After the cycle with k=TAPS-1, go to SAT. MAC lasts exactly TAPS cycles.
- SAT:
  - r = (acc + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT. This is round-half-up.
  - If r is above 2^(OUT_W-1)-1 or below -2^(OUT_W-1), clip to that limit and set out_sat=1; otherwise out_sat=0.
  - Register out_data and set out_valid=1. Go to OUT.
- OUT:
  - out_valid=1, with out_data and out_sat stable.
  - When out_ready... (there is no out_ready port; see below).
- Output handshake: add port out_ready, input, 1, consumer accept. In OUT, the transfer completes when out_valid&out_ready. On that edge out_valid←0 and the state returns to IDLE.
  - in_ready stays 0 in OUT. No sample is accepted on the same edge as an output transfer; the next accept is possible one cycle later.
- Latency: accept edge E0. out_valid rises after edge E0+TAPS+1. Minimum sample period is TAPS+3 cycles.
- Coefficient writes:
  - Performed only when coef_ready (IDLE): coef[coef_addr] ← coef_data.
  - coef_we outside IDLE is ignored and no state changes.
  - A write coinciding with a sample accept is performed, and the new value is used by that computation.
- hist_clr:
  - In IDLE, zeroes all history entries and resets wr_ptr to 0. It has priority over a simultaneous in_valid: that sample is not accepted and in_ready is forced 0 that cycle.
  - Ignored outside IDLE.
- Arithmetic: the accumulator never overflows at ACC_W. Saturation happens only in SAT.

Test Plan:
- Common bench configuration: TAPS=4, DATA_W=16, COEF_W=16, OUT_W=16, SHIFT=0.
- Impulse: coefs {1000,2000,3000,4000}, then inputs 1,0,0,0,0 → outputs 1000,2000,3000,4000,0. out_sat=0 throughout, and out_valid rises 5 cycles after each accept.
- Saturation: all coefs 32767, inputs 32767 ×4 → 4th output 32767 with out_sat=1. Inputs -32768 ×4 (coef 32767) → -32768 with out_sat=1.
- Rounding with SHIFT=2: coef[0]=6 and others 0. Input 1 → 2. Input -1 → -1 ((-6+2)>>>2). Input 0 → 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises → out_data/out_valid stable, in_ready=0, and an in_valid sample is not lost but waits. Raise out_ready → transfer, IDLE, sample accepted next cycle.
- Coefficient lock: coef_we to addr 0 with value 5 during MAC → ignored, coef_ready=0, output uses the old coef. The same write in IDLE → the next output reflects 5.
- Reset/clear: rst mid-MAC → out_valid stays 0 and all history/coefs read 0. hist_clr with in_valid in IDLE → in_ready=0, no accept, and the next impulse reproduces the impulse sequence from a clean history.
